rf_wr_port_arbiter: RTL

- Shares the single register-file write port between two writeback requesters: A = ALU result, B = memory load.
- Round-robin arbitration under a valid/ready handshake.
- Drives the select of the 5-bit write-address mux (mux2to1_5bit), plus the registered write enable, address and data to the register file.
- Sits between the EX/MEM writeback sources and the register file.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/mux2to1_5bit.sv | 11 +
 rtl/rr_pick2.sv | 18 +
 rtl/rf_wr_port_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback-arbiter state encoding, select constants, $0 address.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR_A = 2'b01,
    WR_B = 2'b10
  } wr_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic       SEL_A    = 1'b1;
  localparam logic       SEL_B    = 1'b0;

endpackage

// File: rtl/mux2to1_5bit.sv
// 5-bit 2:1 mux for the register-file write address; sel=1 picks din1.
module mux2to1_5bit (
  input  logic [4:0] din1,
  input  logic [4:0] din2,
  input  logic       sel,
  output logic [4:0] dout
);

  assign dout = sel ? din1 : din2;

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin grant: prio (SEL_A/SEL_B) breaks ties, stall blocks all grants.
module rr_pick2
  import cpu_pkg::*;
(
  input  logic valid_a,
  input  logic valid_b,
  input  logic stall,
  input  logic prio,
  output logic grant_a,
  output logic grant_b,
  output logic contested
);

  assign contested = !stall && valid_a && valid_b;
  assign grant_a   = !stall && valid_a && (!valid_b || (prio == SEL_A));
  assign grant_b   = !stall && valid_b && (!valid_a || (prio == SEL_B));

endmodule

// File: rtl/rf_wr_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B).
// Optional saturating conflict counter enabled by defining RF_ARB_CONFLICT_CNT_EN.
module rf_wr_port_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
`ifdef RF_ARB_CONFLICT_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              valid_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ready_a,
  input  logic              valid_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ready_b,
  output logic              mux_sel,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
`ifdef RF_ARB_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  logic              prio;
  logic              grant_a;
  logic              grant_b;
  logic              contested;
  logic [ADDR_W-1:0] waddr_mux;
  wr_state_t         state;
  wr_state_t         next_state;

  rr_pick2 u_pick (
    .valid_a   (valid_a),
    .valid_b   (valid_b),
    .stall     (stall),
    .prio      (prio),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .contested (contested)
  );

  mux2to1_5bit u_addr_mux (
    .din1 (addr_a),
    .din2 (addr_b),
    .sel  (grant_a),
    .dout (waddr_mux)
  );

  // Handshake is forced low while reset is held.
  assign ready_a = grant_a && rst_n;
  assign ready_b = grant_b && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (grant_a) begin
      next_state = WR_A;
    end else if (grant_b) begin
      next_state = WR_B;
    end else begin
      next_state = IDLE;
    end
  end

  // After a tie the loser gets priority; uncontested grants leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= SEL_A;
    end else if (contested) begin
      prio <= grant_a ? SEL_B : SEL_A;
    end
  end

  // Writes to $0 are acknowledged but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      mux_sel  <= SEL_B;
    end else if (grant_a || grant_b) begin
      rf_we    <= (waddr_mux != REG_ZERO);
      rf_waddr <= waddr_mux;
      rf_wdata <= grant_a ? data_a : data_b;
      mux_sel  <= grant_a ? SEL_A : SEL_B;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef RF_ARB_CONFLICT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (contested && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule
